// File: rtl/branch_resolver_pkg.sv
// rtl/branch_resolver_pkg.sv - shared types and next-PC helper for branch_resolver
package branch_resolver_pkg;

  localparam int ADDRBITWIDTH = 16;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    REDIRECT
  } resolver_state_t;

  typedef struct packed {
    logic [ADDRBITWIDTH-1:0] pc;
    logic                    relative;
    logic                    taken;
    logic [ADDRBITWIDTH-1:0] dest;
  } prediction_t;

  // Same rule for predicted and resolved paths; additions wrap at the address width.
  function automatic logic [ADDRBITWIDTH-1:0] nextPc(
    input logic [ADDRBITWIDTH-1:0] pc,
    input logic                    taken,
    input logic                    relative,
    input logic [ADDRBITWIDTH-1:0] target
  );
    if (!taken)
      return pc + ADDRBITWIDTH'(1);
    else if (relative)
      return pc + target;
    else
      return target;
  endfunction

endpackage

// File: rtl/saturating_counter.sv
// rtl/saturating_counter.sv - up counter that sticks at all-ones
module saturating_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      count <= '0;
    else if (en && (count != '1))
      count <= count + WIDTH'(1);
  end

endmodule

// File: rtl/branch_resolver.sv
// rtl/branch_resolver.sv - resolves speculated branches, reports mispredicts, redirects fetch
module branch_resolver
  import branch_resolver_pkg::*;
#(
  parameter int DATABITWIDTH        = ADDRBITWIDTH,
  parameter int PERFCOUNTERBITWIDTH = 16
) (
  input  logic                           clk,
  input  logic                           async_rst_n,
  input  logic                           clk_en,
  input  logic                           BeginSpeculationPulse,
  input  logic [DATABITWIDTH-1:0]        BranchInstructionAddress,
  input  logic                           RelativeSpeculation,
  input  logic                           PredictingTrue,
  input  logic [DATABITWIDTH-1:0]        SpeculativeDestination,
  input  logic                           ResolveValid,
  input  logic                           ResolveTaken,
  input  logic [DATABITWIDTH-1:0]        ResolveTarget,
  output logic                           ResolveReady,
  output logic                           EndSpeculationPulse,
  output logic                           MispredictedSpeculationPulse,
  output logic [DATABITWIDTH-1:0]        ActualDestination,
  output logic                           Speculating,
  output logic                           RedirectValid,
  output logic [DATABITWIDTH-1:0]        RedirectAddress,
  input  logic                           RedirectReady,
  output logic                           FlushPulse,
  output logic [PERFCOUNTERBITWIDTH-1:0] BranchCount,
  output logic [PERFCOUNTERBITWIDTH-1:0] MispredictCount,
  output logic                           ProtocolError
);

  resolver_state_t         state, nextState;
  prediction_t             captured;
  logic [DATABITWIDTH-1:0] predictedPc;
  logic [DATABITWIDTH-1:0] resolvedPc;
  logic                    beginFire;
  logic                    resolveFire;
  logic                    mispredict;

  assign beginFire   = clk_en && BeginSpeculationPulse && (state == IDLE);
  assign resolveFire = clk_en && ResolveValid && (state == WAIT);

  assign predictedPc = nextPc(captured.pc, captured.taken, captured.relative, captured.dest);
  assign resolvedPc  = nextPc(captured.pc, ResolveTaken, captured.relative, ResolveTarget);
  assign mispredict  = (resolvedPc != predictedPc);

  always_comb begin
    nextState     = state;
    ResolveReady  = 1'b0;
    RedirectValid = 1'b0;
    Speculating   = (state != IDLE);
    case (state)
      IDLE: begin
        if (beginFire)
          nextState = WAIT;
      end
      WAIT: begin
        ResolveReady = 1'b1;
        if (resolveFire)
          nextState = mispredict ? REDIRECT : IDLE;
      end
      REDIRECT: begin
        RedirectValid = 1'b1;
        if (clk_en && RedirectReady)
          nextState = IDLE;
      end
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge async_rst_n) begin
    if (!async_rst_n)
      state <= IDLE;
    else if (clk_en)
      state <= nextState;
  end

  always_ff @(posedge clk or negedge async_rst_n) begin
    if (!async_rst_n) begin
      captured <= '0;
    end else if (beginFire) begin
      captured.pc       <= BranchInstructionAddress;
      captured.relative <= RelativeSpeculation;
      captured.taken    <= PredictingTrue;
      captured.dest     <= SpeculativeDestination;
    end
  end

  // Pulses only change on enabled cycles so each spans exactly one clk_en cycle.
  always_ff @(posedge clk or negedge async_rst_n) begin
    if (!async_rst_n) begin
      EndSpeculationPulse          <= 1'b0;
      MispredictedSpeculationPulse <= 1'b0;
      FlushPulse                   <= 1'b0;
      ActualDestination            <= '0;
      ProtocolError                <= 1'b0;
    end else if (clk_en) begin
      EndSpeculationPulse          <= resolveFire;
      MispredictedSpeculationPulse <= resolveFire && mispredict;
      FlushPulse                   <= resolveFire && mispredict;
      if (resolveFire)
        ActualDestination <= resolvedPc;
      if (BeginSpeculationPulse && (state != IDLE))
        ProtocolError <= 1'b1;
    end
  end

  assign RedirectAddress = ActualDestination;

  saturating_counter #(.WIDTH(PERFCOUNTERBITWIDTH)) branchCounter (
    .clk   (clk),
    .rst_n (async_rst_n),
    .en    (resolveFire),
    .count (BranchCount)
  );

  saturating_counter #(.WIDTH(PERFCOUNTERBITWIDTH)) mispredictCounter (
    .clk   (clk),
    .rst_n (async_rst_n),
    .en    (resolveFire && mispredict),
    .count (MispredictCount)
  );

endmodule

// File: tb/tb_branch_resolver.sv
// tb/tb_branch_resolver.sv - directed self-checking bench for branch_resolver
module tb_branch_resolver;

  logic        clk = 1'b0;
  logic        async_rst_n;
  logic        clk_en;
  logic        BeginSpeculationPulse;
  logic [15:0] BranchInstructionAddress;
  logic        RelativeSpeculation;
  logic        PredictingTrue;
  logic [15:0] SpeculativeDestination;
  logic        ResolveValid;
  logic        ResolveTaken;
  logic [15:0] ResolveTarget;
  logic        ResolveReady;
  logic        EndSpeculationPulse;
  logic        MispredictedSpeculationPulse;
  logic [15:0] ActualDestination;
  logic        Speculating;
  logic        RedirectValid;
  logic [15:0] RedirectAddress;
  logic        RedirectReady;
  logic        FlushPulse;
  logic [1:0]  BranchCount;
  logic [1:0]  MispredictCount;
  logic        ProtocolError;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  branch_resolver #(.DATABITWIDTH(16), .PERFCOUNTERBITWIDTH(2)) dut (
    .clk                          (clk),
    .async_rst_n                  (async_rst_n),
    .clk_en                       (clk_en),
    .BeginSpeculationPulse        (BeginSpeculationPulse),
    .BranchInstructionAddress     (BranchInstructionAddress),
    .RelativeSpeculation          (RelativeSpeculation),
    .PredictingTrue               (PredictingTrue),
    .SpeculativeDestination       (SpeculativeDestination),
    .ResolveValid                 (ResolveValid),
    .ResolveTaken                 (ResolveTaken),
    .ResolveTarget                (ResolveTarget),
    .ResolveReady                 (ResolveReady),
    .EndSpeculationPulse          (EndSpeculationPulse),
    .MispredictedSpeculationPulse (MispredictedSpeculationPulse),
    .ActualDestination            (ActualDestination),
    .Speculating                  (Speculating),
    .RedirectValid                (RedirectValid),
    .RedirectAddress              (RedirectAddress),
    .RedirectReady                (RedirectReady),
    .FlushPulse                   (FlushPulse),
    .BranchCount                  (BranchCount),
    .MispredictCount              (MispredictCount),
    .ProtocolError                (ProtocolError)
  );

  task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beginSpec(input logic [15:0] pc, input logic rel, input logic pred, input logic [15:0] spec);
    BeginSpeculationPulse    = 1'b1;
    BranchInstructionAddress = pc;
    RelativeSpeculation      = rel;
    PredictingTrue           = pred;
    SpeculativeDestination   = spec;
    tick();
    BeginSpeculationPulse    = 1'b0;
  endtask

  task automatic resolve(input logic taken, input logic [15:0] target);
    ResolveValid  = 1'b1;
    ResolveTaken  = taken;
    ResolveTarget = target;
    tick();
    ResolveValid  = 1'b0;
  endtask

  initial begin
    async_rst_n = 1'b0;
    clk_en = 1'b1;
    BeginSpeculationPulse = 1'b0;
    BranchInstructionAddress = '0;
    RelativeSpeculation = 1'b0;
    PredictingTrue = 1'b0;
    SpeculativeDestination = '0;
    ResolveValid = 1'b0;
    ResolveTaken = 1'b0;
    ResolveTarget = '0;
    RedirectReady = 1'b0;
    tick();
    tick();
    chk("rst_speculating", Speculating, 0);
    chk("rst_actual", ActualDestination, 16'h0000);
    chk("rst_branchcount", BranchCount, 0);
    chk("rst_redirectvalid", RedirectValid, 0);
    chk("rst_end", EndSpeculationPulse, 0);
    chk("rst_protoerr", ProtocolError, 0);
    async_rst_n = 1'b1;
    tick();

    // Correct taken relative branch
    beginSpec(16'h0100, 1'b1, 1'b1, 16'h0010);
    chk("t1_speculating", Speculating, 1);
    chk("t1_ready", ResolveReady, 1);
    resolve(1'b1, 16'h0010);
    chk("t1_end", EndSpeculationPulse, 1);
    chk("t1_mispred", MispredictedSpeculationPulse, 0);
    chk("t1_flush", FlushPulse, 0);
    chk("t1_actual", ActualDestination, 16'h0110);
    chk("t1_idle", Speculating, 0);
    chk("t1_branchcount", BranchCount, 1);
    tick();
    chk("t1_end_oneshot", EndSpeculationPulse, 0);

    // Resolve while idle is ignored
    resolve(1'b1, 16'h7777);
    chk("idle_resolve_end", EndSpeculationPulse, 0);
    chk("idle_resolve_count", BranchCount, 1);

    // Wrong direction
    beginSpec(16'h0200, 1'b0, 1'b1, 16'h0400);
    resolve(1'b0, 16'h0000);
    chk("t2_end", EndSpeculationPulse, 1);
    chk("t2_mispred", MispredictedSpeculationPulse, 1);
    chk("t2_flush", FlushPulse, 1);
    chk("t2_actual", ActualDestination, 16'h0201);
    chk("t2_rv_c1", RedirectValid, 1);
    chk("t2_raddr", RedirectAddress, 16'h0201);
    chk("t2_mispredcount", MispredictCount, 1);
    chk("t2_branchcount", BranchCount, 2);
    tick();
    chk("t2_rv_c2", RedirectValid, 1);
    chk("t2_mispred_oneshot", MispredictedSpeculationPulse, 0);
    tick();
    chk("t2_rv_c3", RedirectValid, 1);
    RedirectReady = 1'b1;
    tick();
    RedirectReady = 1'b0;
    chk("t2_rv_drop", RedirectValid, 0);
    chk("t2_idle", Speculating, 0);

    // Wrong absolute target, with a second Begin and a clk_en stall while waiting
    beginSpec(16'h0300, 1'b0, 1'b1, 16'h1234);
    beginSpec(16'h0AAA, 1'b1, 1'b0, 16'h5555);
    chk("t3_protoerr", ProtocolError, 1);
    chk("t3_still_wait", ResolveReady, 1);
    clk_en = 1'b0;
    ResolveValid = 1'b1;
    ResolveTaken = 1'b1;
    ResolveTarget = 16'h1238;
    tick();
    tick();
    ResolveValid = 1'b0;
    chk("t3_clken_end", EndSpeculationPulse, 0);
    chk("t3_clken_count", BranchCount, 2);
    chk("t3_clken_wait", ResolveReady, 1);
    clk_en = 1'b1;
    resolve(1'b1, 16'h1238);
    chk("t3_mispred", MispredictedSpeculationPulse, 1);
    chk("t3_actual", ActualDestination, 16'h1238);
    chk("t3_raddr", RedirectAddress, 16'h1238);
    chk("t3_rv", RedirectValid, 1);
    chk("t3_branchcount", BranchCount, 3);
    chk("t3_mispredcount", MispredictCount, 2);

    // Asynchronous reset while in REDIRECT
    #3;
    async_rst_n = 1'b0;
    #1;
    chk("arst_rv", RedirectValid, 0);
    chk("arst_speculating", Speculating, 0);
    chk("arst_branchcount", BranchCount, 0);
    chk("arst_mispredcount", MispredictCount, 0);
    chk("arst_protoerr", ProtocolError, 0);
    chk("arst_actual", ActualDestination, 16'h0000);
    tick();
    chk("arst_no_end", EndSpeculationPulse, 0);
    async_rst_n = 1'b1;
    tick();

    // Wrap-around
    beginSpec(16'hFFFF, 1'b0, 1'b0, 16'h0000);
    resolve(1'b0, 16'h0000);
    chk("wrap1_actual", ActualDestination, 16'h0000);
    chk("wrap1_mispred", MispredictedSpeculationPulse, 0);
    chk("wrap1_end", EndSpeculationPulse, 1);
    beginSpec(16'hFFF0, 1'b1, 1'b1, 16'h0020);
    resolve(1'b1, 16'h0020);
    chk("wrap2_actual", ActualDestination, 16'h0010);
    chk("wrap2_mispred", MispredictedSpeculationPulse, 0);
    chk("wrap2_branchcount", BranchCount, 2);

    // Saturation: three more branches brings the total to five
    for (int i = 0; i < 3; i++) begin
      beginSpec(16'h0040 + 16'(i), 1'b0, 1'b0, 16'h0000);
      resolve(1'b0, 16'h0000);
    end
    chk("sat_branchcount", BranchCount, 3);
    chk("sat_mispredcount", MispredictCount, 0);
    chk("sat_last_actual", ActualDestination, 16'h0043);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
